// File: rtl/seq_alu.sv
// seq_alu: registered ALU with iterative multiply; iterative divide only when SEQ_ALU_DIV_EN is defined.
// Latency: done in cycle 1 for single-cycle ops, in cycle WIDTH+1 for multiply/divide (cycle 0 samples start).
// Backpressure: start is ignored while busy; there is no queuing, the caller must wait for busy=0.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [6:0] LAST = 7'(WIDTH - 1);

  logic [1:0]         state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [6:0]         cnt;

  logic               accept;
  logic               is_multi;
  logic               fin_multi;
  logic               fin_single;
  logic [WIDTH-1:0]   s_y;
  logic               s_zero;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] step_next;
  logic [WIDTH-1:0]   m_y;

  assign busy       = (state == CALC);
  assign done       = (state == DONE);
  assign accept     = start && (state != CALC);
  assign fin_multi  = (state == CALC) && (cnt == LAST);
  assign fin_single = accept && !is_multi;

  // Shift-add multiply: acc = {partial high, multiplier remaining}, one bit retired per cycle.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] div_next;
  logic               s_dz;

  // Restoring divide: acc = {remainder, dividend/quotient}; the borrow bit of the trial
  // subtraction decides restore vs. keep and is the inverted quotient bit.
  always_comb begin
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    div_next = {(rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0]),
                acc[WIDTH-2:0], ~rem_diff[WIDTH]};
  end

  assign step_next = op_q[1] ? div_next : mul_next;
`else
  assign step_next = mul_next;
`endif

  always_comb begin
    case (op_q)
      4'b1000: m_y = step_next[WIDTH-1:0];
      4'b1001: m_y = step_next[2*WIDTH-1:WIDTH];
`ifdef SEQ_ALU_DIV_EN
      4'b1010: m_y = step_next[WIDTH-1:0];
      4'b1011: m_y = step_next[2*WIDTH-1:WIDTH];
`endif
      default: m_y = '0;
    endcase
  end

  always_comb begin
    s_y      = '0;
    s_zero   = 1'b0;
    is_multi = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    s_dz     = 1'b0;
`endif
    case (op)
      4'b0000: s_y = b;
      4'b0001: s_y = a | b;
      4'b0010: s_y = a + b;
      4'b0011: s_y = a - b;
      4'b0110: s_zero = (a == b);
      4'b0111: s_y = a & b;
      4'b1000, 4'b1001: is_multi = 1'b1;
`ifdef SEQ_ALU_DIV_EN
      4'b1010, 4'b1011: begin
        if (b == '0) begin
          s_dz = 1'b1;
          s_y  = op[0] ? a : '1;
        end else begin
          is_multi = 1'b1;
        end
      end
`endif
      default: s_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      y     <= '0;
      zero  <= 1'b0;
      op_q  <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        CALC: begin
          acc <= step_next;
          cnt <= cnt + 7'd1;
          if (fin_multi) begin
            state <= DONE;
            y     <= m_y;
            zero  <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            op_q <= op;
            b_q  <= b;
            acc  <= {{WIDTH{1'b0}}, a};
            cnt  <= '0;
            if (is_multi) begin
              state <= CALC;
            end else begin
              state <= DONE;
              y     <= s_y;
              zero  <= s_zero;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef SEQ_ALU_DIV_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dz <= 1'b0;
    end else if (fin_multi) begin
      dz <= 1'b0;
    end else if (fin_single) begin
      dz <= s_dz;
    end
  end
`else
  assign dz = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=32): vector table through a scoreboard plus hand-built multi-cycle sequences.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;
  logic         zero;
  logic         busy;
  logic         done;
  logic         dz;

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .y     (y),
    .zero  (zero),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         zero;
    logic         dz;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] y;
    logic         zero;
    logic         dz;
    int           lat;
    int           issue;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("y", y, e.y);
        chk("zero", zero, e.zero);
        chk("dz", dz, e.dz);
        chk("latency", cyc - e.issue, e.lat);
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] ey, input logic ez, input logic edz,
                       input int elat, input bit expect_done);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = ia;
    b     = ib;
    if (expect_done) begin
      e.y     = ey;
      e.zero  = ez;
      e.dz    = edz;
      e.lat   = elat;
      e.issue = cyc;
      sbq.push_back(e);
    end
    @(negedge clk);
    // Scramble inputs so a design that fails to latch them produces wrong results.
    start = 1'b0;
    op    = 4'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic drain();
    int i = 0;
    while (sbq.size() != 0 && i < 100) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("drain_timeout", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_y", y, 0);
    chk("rst_zero", zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", dz, 0);
    reset = 1'b0;
    @(negedge clk);

    vt.push_back('{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1});
    vt.push_back('{4'b0011, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1});
    vt.push_back('{4'b0011, 32'h0000000A, 32'h00000003, 32'h00000007, 1'b0, 1'b0, 1});
    vt.push_back('{4'b0010, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0, 1'b0, 1});
    vt.push_back('{4'b0000, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1});
    vt.push_back('{4'b0001, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0, 1'b0, 1});
    vt.push_back('{4'b0111, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0, 1});
    vt.push_back('{4'b0110, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b0, 1});
    vt.push_back('{4'b0010, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 1});
    vt.push_back('{4'b0110, 32'h00001234, 32'h00001235, 32'h00000000, 1'b0, 1'b0, 1});
    vt.push_back('{4'b0100, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b0, 1});
    vt.push_back('{4'b1100, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0, 1'b0, 1});
    vt.push_back('{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1});
    vt.push_back('{4'b1000, 32'h00000007, 32'h00000006, 32'h0000002A, 1'b0, 1'b0, 33});
    vt.push_back('{4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 33});
    vt.push_back('{4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 33});
    vt.push_back('{4'b1001, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0, 1'b0, 33});
    vt.push_back('{4'b1000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 33});
`ifdef SEQ_ALU_DIV_EN
    vt.push_back('{4'b1010, 32'd100,       32'd7,        32'd14,        1'b0, 1'b0, 33});
    vt.push_back('{4'b1011, 32'd100,       32'd7,        32'd2,         1'b0, 1'b0, 33});
    vt.push_back('{4'b1010, 32'd100,       32'd0,        32'hFFFFFFFF,  1'b0, 1'b1, 1});
    vt.push_back('{4'b1011, 32'h0000ABCD,  32'd0,        32'h0000ABCD,  1'b0, 1'b1, 1});
    vt.push_back('{4'b1010, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF,  1'b0, 1'b0, 33});
    vt.push_back('{4'b1011, 32'hFFFFFFFF,  32'd10,       32'd5,         1'b0, 1'b0, 33});
    vt.push_back('{4'b1010, 32'd7,         32'd100,      32'd0,         1'b0, 1'b0, 33});
    vt.push_back('{4'b1011, 32'd7,         32'd100,      32'd7,         1'b0, 1'b0, 33});
`else
    vt.push_back('{4'b1010, 32'd100,       32'd7,        32'd0,         1'b0, 1'b0, 1});
    vt.push_back('{4'b1011, 32'd100,       32'd7,        32'd0,         1'b0, 1'b0, 1});
    vt.push_back('{4'b1010, 32'd100,       32'd0,        32'd0,         1'b0, 1'b0, 1});
`endif

    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].y, vt[i].zero, vt[i].dz, vt[i].lat, 1'b1);
      drain();
    end

    // Back-to-back: compare sets zero, the add issued in its done cycle clears it.
    issue(4'b0110, 32'd1234, 32'd1234, 32'd0, 1'b1, 1'b0, 1, 1'b1);
    issue(4'b0010, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0, 1, 1'b1);
    drain();

    // Busy window of a multiply, with a start pulse during busy that must be ignored.
    issue(4'b1000, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 33, 1'b1);
    chk("busy_cycle1", busy, 1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op    = 4'b0010;
    a     = 32'd1;
    b     = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (27) @(negedge clk);
    chk("busy_cycle32", busy, 1);
    chk("done_cycle32", done, 0);
    drain();
    chk("busy_after_mul", busy, 0);
    repeat (5) @(negedge clk);
    chk("y_hold", y, 32'd42);

    // Reset in cycle 10 of a multiply discards it: no done pulse afterwards.
    issue(4'b1000, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_y", y, 0);
    chk("midrst_done", done, 0);
    repeat (40) @(negedge clk);
    chk("midrst_idle", busy, 0);

    // Reset wins over a simultaneous start.
    issue(4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1, 1'b1);
    drain();
    reset = 1'b1;
    start = 1'b1;
    op    = 4'b0010;
    a     = 32'd10;
    b     = 32'd10;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("rstprio_done", done, 0);
    chk("rstprio_y", y, 0);
    chk("rstprio_busy", busy, 0);
    @(negedge clk);
    chk("rstprio_done2", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal range 4..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only while busy=0.
REQ-005 SHALL have port op, input, 4 bits: operation select.
REQ-006 SHALL have ports a and b, inputs, WIDTH bits each: operands.
REQ-007 SHALL have port y, output, WIDTH bits: registered result.
REQ-008 SHALL have port zero, output, 1 bit: registered equality flag.
REQ-009 SHALL have port busy, output, 1 bit: high while a multi-cycle op iterates.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when y/zero/dz are updated.
REQ-011 SHALL have port dz, output, 1 bit: divide-by-zero flag of the last completed op.

Function
REQ-012 SHALL implement these op codes:
- 0000 y=b
- 0001 y=a|b
- 0010 y=a+b
- 0011 y=a-b (two's complement)
- 0110 zero=(a==b), y=0
- 0111 y=a&b
- 1000 y=low WIDTH bits of unsigned a*b
- 1001 y=high WIDTH bits of unsigned a*b
- 1010 y=unsigned a/b
- 1011 y=unsigned a%b
REQ-013 SHALL, on every op other than 0110, drive zero=0 at completion; sums and differences SHALL wrap modulo 2^WIDTH, with no carry or overflow output.
REQ-014 SHALL treat undefined op codes as single-cycle ops yielding y=0, zero=0, dz=0.
REQ-015 SHALL latch op, a and b on the edge that accepts start; later input changes SHALL NOT affect that operation.
REQ-016 SHALL use a state machine with states IDLE, CALC and DONE.
REQ-017 SHALL move IDLE/DONE to DONE on start for single-cycle ops, so done is high in cycle 1, where cycle 0 is the cycle start is sampled.
REQ-018 SHALL move IDLE/DONE to CALC on start for ops 1000..1011 (except divide by zero); CALC SHALL perform one shift-add or restoring-subtract step per cycle for exactly WIDTH cycles, then go to DONE.
- busy is high in cycles 1..WIDTH.
- done is high in cycle WIDTH+1.
REQ-019 SHALL leave DONE after one cycle, to IDLE without start or to the next op with start (back-to-back ops allowed).
REQ-020 SHALL ignore start while busy=1; no queuing.
REQ-021 SHALL complete ops 1010/1011 with b=0 as single-cycle ops: dz=1, quotient = all ones, remainder = a; dz=0 for every other op.
REQ-022 SHALL hold y, zero and dz stable between done pulses.

Reset
REQ-023 SHALL, when reset is high at a clock edge, including mid-CALC:
- enter IDLE
- set y=0, zero=0, busy=0, done=0, dz=0
- discard the partial result.
REQ-024 SHALL give reset priority over start on the same edge.

Configuration
REQ-025 SHALL include the iterative divider (ops 1010/1011, dz) only when macro SEQ_ALU_DIV_EN is defined.
REQ-026 SHALL, without SEQ_ALU_DIV_EN, treat ops 1010/1011 as undefined (REQ-014) with dz tied to 0, and contain no divider logic.

Verification (WIDTH=32)
REQ-027 SHALL cover single-cycle ops: add a=7FFFFFFF, b=1 -> done in cycle 1, y=80000000; sub a=0, b=1 -> y=FFFFFFFF.
REQ-028 SHALL cover compare: op 0110, a=b=1234 -> zero=1, y=0; next op 0010 -> zero=0.
REQ-029 SHALL cover multiply: op 1000 a=7, b=6 -> busy cycles 1..32, done in cycle 33, y=42; op 1001 a=b=FFFFFFFF -> y=FFFFFFFE.
REQ-030 SHALL cover divide (macro on):
- op 1010 a=100, b=7 -> y=14 at cycle 33.
- op 1011 -> y=2.
- b=0 -> done in cycle 1, dz=1, y=FFFFFFFF.
REQ-031 SHALL cover reset and start during busy:
- reset in cycle 10 of a multiply -> next cycle busy=0, y=0, no done pulse.
- start pulsed during busy -> ignored, result unchanged.
REQ-032 SHALL cover the macro off: op 1010 -> done in cycle 1, y=0, dz=0.
